// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: capture stream vs. auxiliary writer, plus a full-buffer clear sequencer.
// Every RAM-side output is registered, so a write appears one cycle after its request is sampled.
module fb_write_arbiter #(
  parameter int FB_WORDS     = 192000,
  parameter int AUX_MAX_WAIT = 15
) (
  input  logic        dotclk,
  input  logic        reset,
  input  logic        cap_valid,
  input  logic [17:0] cap_addr,
  input  logic        cap_pixel,
  input  logic        clr_start,
  input  logic        aux_req,
  input  logic [17:0] aux_addr,
  input  logic        aux_pixel,
  output logic        aux_ack,
  output logic [17:0] waddr,
  output logic        pixel_state,
  output logic        wren,
  output logic        clearing,
  output logic        clr_done,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {S_NORMAL, S_CLEAR, S_DONE} state_t;

  localparam logic [18:0] FB_LIMIT  = 19'(FB_WORDS);
  localparam logic [17:0] LAST_ADDR = 18'(FB_WORDS - 1);
  localparam logic [15:0] WAIT_MAX  = 16'(AUX_MAX_WAIT);

  state_t      state_q, state_d;
  logic [17:0] clr_cnt_q, clr_cnt_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] drop_q, drop_d;
  logic [17:0] waddr_q, waddr_d;
  logic        pix_q, pix_d;
  logic        wren_q, wren_d;
  logic        ack_q, ack_d;
  logic        clearing_q, clearing_d;
  logic        done_q, done_d;
  logic        cap_in_range, aux_in_range, aux_grant, drop_inc;

  assign cap_in_range = {1'b0, cap_addr} < FB_LIMIT;
  assign aux_in_range = {1'b0, aux_addr} < FB_LIMIT;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_d     = wait_q;
    waddr_d    = waddr_q;
    pix_d      = pix_q;
    wren_d     = 1'b0;
    ack_d      = 1'b0;
    clearing_d = 1'b0;
    done_d     = 1'b0;
    drop_inc   = 1'b0;
    aux_grant  = 1'b0;
    unique case (state_q)
      S_NORMAL: begin
        // Capture normally wins; a starved aux request eventually preempts it.
        aux_grant = aux_req && (!cap_valid || wait_q == WAIT_MAX);
        if (aux_grant) begin
          ack_d    = 1'b1;
          wait_d   = 16'd0;
          drop_inc = cap_valid;
          if (aux_in_range) begin
            wren_d  = 1'b1;
            waddr_d = aux_addr;
            pix_d   = aux_pixel;
          end
        end else begin
          wait_d = aux_req ? wait_q + 16'd1 : 16'd0;
          if (cap_valid) begin
            if (cap_in_range) begin
              wren_d  = 1'b1;
              waddr_d = cap_addr;
              pix_d   = cap_pixel;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = 18'd0;
        end
      end
      S_CLEAR: begin
        wren_d     = 1'b1;
        waddr_d    = clr_cnt_q;
        pix_d      = 1'b0;
        clearing_d = 1'b1;
        drop_inc   = cap_valid;
        if (!aux_req) wait_d = 16'd0;
        if (clr_start) begin
          clr_cnt_d = 18'd0;
        end else if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_DONE;
          clr_cnt_d = 18'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 18'd1;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        drop_inc  = cap_valid;
        clr_cnt_d = 18'd0;
        if (!aux_req) wait_d = 16'd0;
        state_d   = clr_start ? S_CLEAR : S_NORMAL;
      end
      default: state_d = S_NORMAL;
    endcase
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge dotclk) begin
    if (reset) begin
      state_q    <= S_NORMAL;
      clr_cnt_q  <= 18'd0;
      wait_q     <= 16'd0;
      drop_q     <= 16'd0;
      waddr_q    <= 18'd0;
      pix_q      <= 1'b0;
      wren_q     <= 1'b0;
      ack_q      <= 1'b0;
      clearing_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
      waddr_q    <= waddr_d;
      pix_q      <= pix_d;
      wren_q     <= wren_d;
      ack_q      <= ack_d;
      clearing_q <= clearing_d;
      done_q     <= done_d;
    end
  end

  assign aux_ack     = ack_q;
  assign waddr       = waddr_q;
  assign pixel_state = pix_q;
  assign wren        = wren_q;
  assign clearing    = clearing_q;
  assign clr_done    = done_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the arbitration rules.
module tb_fb_write_arbiter;
  localparam int FBW  = 16;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cap_valid, cap_pixel, clr_start, aux_req, aux_pixel;
  logic [17:0] cap_addr, aux_addr;
  logic        aux_ack, pixel_state, wren, clearing, clr_done;
  logic [17:0] waddr;
  logic [15:0] drop_count;

  logic        d_cap_valid, d_cap_pixel, d_zero;
  logic [17:0] d_cap_addr, d_zero_addr;
  logic        d_aux_ack, d_pixel_state, d_wren, d_clearing, d_clr_done;
  logic [17:0] d_waddr;
  logic [15:0] d_drop_count;

  fb_write_arbiter #(.FB_WORDS(FBW), .AUX_MAX_WAIT(MAXW)) dut (
    .dotclk(clk), .reset(reset), .cap_valid(cap_valid), .cap_addr(cap_addr),
    .cap_pixel(cap_pixel), .clr_start(clr_start), .aux_req(aux_req),
    .aux_addr(aux_addr), .aux_pixel(aux_pixel), .aux_ack(aux_ack), .waddr(waddr),
    .pixel_state(pixel_state), .wren(wren), .clearing(clearing),
    .clr_done(clr_done), .drop_count(drop_count)
  );

  // Default-sized instance, used only for the large-address scenarios (never cleared).
  fb_write_arbiter dut_def (
    .dotclk(clk), .reset(reset), .cap_valid(d_cap_valid), .cap_addr(d_cap_addr),
    .cap_pixel(d_cap_pixel), .clr_start(d_zero), .aux_req(d_zero),
    .aux_addr(d_zero_addr), .aux_pixel(d_zero), .aux_ack(d_aux_ack), .waddr(d_waddr),
    .pixel_state(d_pixel_state), .wren(d_wren), .clearing(d_clearing),
    .clr_done(d_clr_done), .drop_count(d_drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Model of the small instance: m_clr_pos is the next address to clear, -1 when not clearing.
  int          m_clr_pos, m_waited, m_drops;
  bit          m_done_next;
  logic [17:0] m_addr;
  logic        m_pix;
  logic        e_wren, e_ack, e_clearing, e_done;

  task automatic model_step();
    bit aux_turn;
    e_wren = 1'b0; e_ack = 1'b0; e_clearing = 1'b0; e_done = 1'b0;
    if (reset) begin
      m_clr_pos = -1; m_done_next = 1'b0; m_waited = 0; m_drops = 0;
      m_addr = '0; m_pix = 1'b0;
      return;
    end
    if (m_clr_pos >= 0) begin
      e_wren = 1'b1; e_clearing = 1'b1; m_addr = 18'(m_clr_pos); m_pix = 1'b0;
      if (cap_valid) m_drops++;
      if (!aux_req) m_waited = 0;
      if (clr_start) m_clr_pos = 0;
      else if (m_clr_pos == FBW - 1) begin m_clr_pos = -1; m_done_next = 1'b1; end
      else m_clr_pos++;
    end else if (m_done_next) begin
      e_done = 1'b1; m_done_next = 1'b0;
      if (cap_valid) m_drops++;
      if (!aux_req) m_waited = 0;
      if (clr_start) m_clr_pos = 0;
    end else begin
      aux_turn = aux_req && (!cap_valid || m_waited == MAXW);
      if (aux_turn) begin
        e_ack = 1'b1; m_waited = 0;
        if (cap_valid) m_drops++;
        if (aux_addr < FBW) begin e_wren = 1'b1; m_addr = aux_addr; m_pix = aux_pixel; end
      end else begin
        if (aux_req) m_waited++; else m_waited = 0;
        if (cap_valid) begin
          if (cap_addr < FBW) begin e_wren = 1'b1; m_addr = cap_addr; m_pix = cap_pixel; end
          else m_drops++;
        end
      end
      if (clr_start) m_clr_pos = 0;
    end
    if (m_drops > 65535) m_drops = 65535;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(); cycle();
    checks++;
    if ({wren, waddr, pixel_state, aux_ack, clearing, clr_done, drop_count} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", {wren, waddr, pixel_state, aux_ack, clearing, clr_done, drop_count});
    end
    checks++;
    if ({d_wren, d_waddr, d_pixel_state, d_aux_ack, d_clearing, d_clr_done, d_drop_count} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state_def got=%h want=0", {d_wren, d_waddr, d_pixel_state, d_aux_ack, d_clearing, d_clr_done, d_drop_count});
    end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_capture();
    d_cap_valid = 1'b1; d_cap_addr = 18'd1234; d_cap_pixel = 1'b1;
    cycle();
    d_cap_valid = 1'b0;
    checks++;
    if ({d_wren, d_waddr, d_pixel_state, d_drop_count} !== {1'b1, 18'd1234, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL capture_write got=%h want=%h", {d_wren, d_waddr, d_pixel_state, d_drop_count}, {1'b1, 18'd1234, 1'b1, 16'd0});
    end
    cycle();
    checks++;
    if ({d_wren, d_waddr, d_pixel_state} !== {1'b0, 18'd1234, 1'b1}) begin
      errors++;
      $display("FAIL idle_hold got=%h want=%h", {d_wren, d_waddr, d_pixel_state}, {1'b0, 18'd1234, 1'b1});
    end
    $display("capture: addr 1234 pixel 1 then idle");
  endtask

  task automatic test_oor_saturate();
    d_cap_valid = 1'b1; d_cap_addr = 18'd200000; d_cap_pixel = 1'b1;
    cycle();
    checks++;
    if ({d_wren, d_waddr, d_drop_count} !== {1'b0, 18'd1234, 16'd1}) begin
      errors++;
      $display("FAIL oor_drop got=%h want=%h", {d_wren, d_waddr, d_drop_count}, {1'b0, 18'd1234, 16'd1});
    end
    for (int i = 1; i < 65540; i++) cycle();
    d_cap_valid = 1'b0;
    checks++;
    if (d_drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate got=%h want=ffff", d_drop_count);
    end
    $display("oor: 65540 drops, drop_count=%h", d_drop_count);
  endtask

  task automatic test_aux_starve();
    logic [17:0] a;
    logic        p;
    logic [20:0] want;
    aux_addr = 18'd9; aux_pixel = 1'b1; aux_req = 1'b1; cap_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cap_addr = 18'($urandom_range(0, FBW - 1)); cap_pixel = 1'($urandom_range(0, 1));
      a = cap_addr; p = cap_pixel;
      cycle();
      want = (k == 16) ? {1'b1, 18'd9, 1'b1, 1'b1} : {1'b1, a, p, 1'b0};
      checks++;
      if ({wren, waddr, pixel_state, aux_ack} !== want) begin
        errors++;
        $display("FAIL aux_starve_cycle%0d got=%h want=%h", k, {wren, waddr, pixel_state, aux_ack}, want);
      end
      $display("starve: cycle %0d ack=%b waddr=%0d", k, aux_ack, waddr);
    end
    aux_req = 1'b0; cap_valid = 1'b0;
    checks++;
    if (drop_count !== 16'd1) begin
      errors++;
      $display("FAIL aux_starve_drops got=%0d want=1", drop_count);
    end
    cycle();
  endtask

  task automatic test_clear();
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    checks++;
    if ({wren, clearing} !== 2'b00) begin
      errors++;
      $display("FAIL clear_start_cycle got=%b want=00", {wren, clearing});
    end
    for (int i = 0; i < FBW; i++) begin
      cycle();
      checks++;
      if ({wren, waddr, pixel_state, clearing, clr_done} !== {1'b1, 18'(i), 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL clear_write%0d got=%h want=%h", i, {wren, waddr, pixel_state, clearing, clr_done}, {1'b1, 18'(i), 1'b0, 1'b1, 1'b0});
      end
      $display("clear: write addr %0d", waddr);
    end
    cycle();
    checks++;
    if ({wren, clearing, clr_done} !== 3'b001) begin
      errors++;
      $display("FAIL clear_done got=%b want=001", {wren, clearing, clr_done});
    end
    cycle();
    checks++;
    if ({wren, clearing, clr_done} !== 3'b000) begin
      errors++;
      $display("FAIL clear_after_done got=%b want=000", {wren, clearing, clr_done});
    end
  endtask

  task automatic test_clear_restart();
    int writes = 0;
    int dones = 0;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (wren && clearing) writes++;
    end
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    if (wren && clearing) writes++;
    checks++;
    if (waddr !== 18'd8) begin
      errors++;
      $display("FAIL restart_at8 got=%0d want=8", waddr);
    end
    cycle();
    if (wren && clearing) writes++;
    checks++;
    if ({wren, waddr, clearing} !== {1'b1, 18'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_addr0 got=%h want=%h", {wren, waddr, clearing}, {1'b1, 18'd0, 1'b1});
    end
    for (int n = 0; n < 40 && dones == 0; n++) begin
      cycle();
      if (wren && clearing) writes++;
      if (clr_done) dones++;
    end
    cycle();
    if (clr_done) dones++;
    checks++;
    if (writes != 25 || dones != 1) begin
      errors++;
      $display("FAIL restart_totals got writes=%0d dones=%0d want writes=25 dones=1", writes, dones);
    end
    $display("restart: %0d clear writes, %0d clr_done", writes, dones);
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    aux_req = 1'b1; aux_addr = 18'd3; aux_pixel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (aux_ack) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL aux_acked_in_clear got=%0d want=0", bad);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if ({wren, waddr, pixel_state, aux_ack, clearing, clr_done, drop_count} !== 39'd0) begin
      errors++;
      $display("FAIL reset_mid_clear got=%h want=0", {wren, waddr, pixel_state, aux_ack, clearing, clr_done, drop_count});
    end
    cycle();
    aux_req = 1'b0;
    checks++;
    if ({wren, waddr, pixel_state, aux_ack, clearing, clr_done} !== {1'b1, 18'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL aux_after_reset got=%h want=%h", {wren, waddr, pixel_state, aux_ack, clearing, clr_done}, {1'b1, 18'd3, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (clr_done || clearing) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_done_after_abort got=%0d want=0", bad);
    end
    $display("reset_mid_clear: aux acked at addr %0d after release", waddr);
  endtask

  task automatic test_random();
    logic [38:0] got, want;
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 499) == 0);
      cap_valid = 1'($urandom_range(0, 1));
      cap_addr  = 18'($urandom_range(0, 19));
      cap_pixel = 1'($urandom_range(0, 1));
      clr_start = ($urandom_range(0, 149) == 0);
      if (!aux_req || e_ack) begin
        aux_req   = ($urandom_range(0, 2) == 0);
        aux_addr  = 18'($urandom_range(0, 19));
        aux_pixel = 1'($urandom_range(0, 1));
      end
      cycle();
      got  = {wren, waddr, pixel_state, aux_ack, clearing, clr_done, drop_count};
      want = {e_wren, m_addr, m_pix, e_ack, e_clearing, e_done, 16'(m_drops)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h want=%h", n, got, want);
      end
      if (e_ack) $display("random: cycle %0d aux grant addr %0d wren %b", n, aux_addr, e_wren);
    end
    reset = 1'b0; cap_valid = 1'b0; clr_start = 1'b0; aux_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cap_valid = 1'b0; cap_addr = '0; cap_pixel = 1'b0; clr_start = 1'b0;
    aux_req = 1'b0; aux_addr = '0; aux_pixel = 1'b0;
    d_cap_valid = 1'b0; d_cap_addr = '0; d_cap_pixel = 1'b0; d_zero = 1'b0; d_zero_addr = '0;
    m_clr_pos = -1; m_done_next = 1'b0; m_waited = 0; m_drops = 0; m_addr = '0; m_pix = 1'b0;
    e_wren = 1'b0; e_ack = 1'b0; e_clearing = 1'b0; e_done = 1'b0;
    test_reset();
    test_capture();
    test_oor_saturate();
    test_aux_starve();
    test_clear();
    test_clear_restart();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_WORDS, default 192000, frame-buffer depth in pixels.
REQ-002 SHALL have parameter AUX_MAX_WAIT, default 15, max consecutive denied aux cycles before forced aux grant.
REQ-003 dotclk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cap_valid  in  1  capture pixel write request, one per cycle, no backpressure.
REQ-006 cap_addr  in  18  capture write address.
REQ-007 cap_pixel  in  1  capture pixel value.
REQ-008 clr_start  in  1  one-cycle pulse requesting a full frame-buffer clear.
REQ-009 aux_req  in  1  auxiliary writer request, held until aux_ack.
REQ-010 aux_addr  in  18  aux write address, stable while aux_req high.
REQ-011 aux_pixel  in  1  aux pixel value, stable while aux_req high.
REQ-012 aux_ack  out  1  one-cycle pulse: aux request consumed.
REQ-013 waddr  out  18  RAM write address (registered).
REQ-014 pixel_state  out  1  RAM write data (registered).
REQ-015 wren  out  1  RAM write enable (registered).
REQ-016 clearing  out  1  high while in CLEAR state.
REQ-017 clr_done  out  1  one-cycle pulse at clear completion.
REQ-018 drop_count  out  16  count of discarded capture writes, saturating.

Function
REQ-019 States SHALL be NORMAL, CLEAR, DONE; all outputs registered, latency 1 cycle from sampled request to wren/waddr/pixel_state.
REQ-020 NORMAL: cap_valid wins over aux_req; write issued with cap_addr/cap_pixel, wren=1.
REQ-021 NORMAL: aux granted when cap_valid=0 and aux_req=1; aux_ack=1 on the same edge wren=1 for that write.
REQ-022 Aux wait counter SHALL increment each NORMAL cycle aux_req=1 and aux not granted; clear to 0 on grant, reset, or aux_req=0.
REQ-023 When wait counter == AUX_MAX_WAIT and aux_req=1, aux SHALL be granted even if cap_valid=1; that capture write is dropped (drop_count+1).
REQ-024 aux_req still high the cycle after aux_ack SHALL be treated as a new request.
REQ-025 Capture write with cap_addr >= FB_WORDS SHALL be suppressed (wren=0) and counted in drop_count; aux with aux_addr >= FB_WORDS acked with wren=0.
REQ-026 clr_start in NORMAL: current-cycle arbitration proceeds normally; state -> CLEAR next edge; clear counter = 0.
REQ-027 CLEAR: each cycle write waddr=counter, pixel_state=0, wren=1, counter+1; clearing=1.
REQ-028 CLEAR: cap_valid=1 cycles SHALL be dropped and counted; aux_req held, not acked, wait counter frozen.
REQ-029 CLEAR: after write of address FB_WORDS-1, state -> DONE; exactly FB_WORDS clear writes issued.
REQ-030 clr_start during CLEAR SHALL restart counter at 0 (clear restarts, no clr_done for aborted pass).
REQ-031 DONE: one cycle, clr_done=1, wren=0, clearing=0, no grants; then NORMAL.
REQ-032 clr_start during DONE SHALL enter CLEAR next edge, clr_done still pulsed.
REQ-033 drop_count SHALL saturate at 16'hFFFF, never wrap.
REQ-034 Idle cycles (no grant, NORMAL) SHALL drive wren=0; waddr/pixel_state hold last value.

Reset
REQ-035 reset=1 at a rising edge SHALL force state NORMAL, wren=0, waddr=0, pixel_state=0, aux_ack=0, clearing=0, clr_done=0, drop_count=0, wait and clear counters 0.
REQ-036 reset mid-CLEAR SHALL abort clear with no clr_done pulse; reset dominates all inputs that cycle.

Verification
REQ-037 cap_valid=1, cap_addr=1234, cap_pixel=1 in NORMAL -> next cycle wren=1, waddr=1234, pixel_state=1, drop_count=0.
REQ-038 cap_valid and aux_req held high 20 cycles, AUX_MAX_WAIT=15 -> aux_ack on 16th cycle's write, drop_count=1, capture resumes.
REQ-039 clr_start pulse, FB_WORDS=16 -> 16 writes addr 0..15 pixel 0, clearing high 16 cycles, then clr_done 1 cycle, NORMAL.
REQ-040 clr_start at clear counter 8, FB_WORDS=16 -> addresses restart at 0, total 25 clear writes, one clr_done.
REQ-041 cap_addr=200000 with default FB_WORDS -> wren=0, drop_count=1; drop_count preloaded via 65540 drops -> reads 65535.
REQ-042 reset asserted at clear counter 5 -> next cycle all outputs reset values, no clr_done, aux_req pending then acked after reset release.
